textbuffer_console: RTL and testbench

- Terminal-style sequencer that drives the text buffer's 12-bit CPU-side memory port.
- Accepts a byte stream of characters and control codes and maintains a cursor.
- Writes character and attribute cells; performs scroll-up and clear-screen as multi-cycle memory sequences.
- Shares the port with a direct CPU requester; the CPU always has priority. Sits between the CPU bus decode and the text buffer.

---
 rtl/console_pkg.sv | 34 +++
 rtl/console_port_mux.sv | 36 +++
 rtl/textbuffer_console.sv | 203 ++++++++++++++++++++
 tb/tb_textbuffer_console.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared types and constants for the text-buffer console sequencer.
package console_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_C,
    WR_A,
    CLR_C,
    CLR_A,
    SCR_RD_C,
    SCR_WR_C,
    SCR_RD_A,
    SCR_WR_A,
    FILL_C,
    FILL_A
  } state_t;

  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] DEL   = 8'h7F;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= SPACE) && (b != DEL);
  endfunction

  function automatic logic [11:0] cell_off(input logic [3:0] row, input logic [4:0] col,
                                           input logic [11:0] width);
    return ({8'b0, row} * width) + {7'b0, col};
  endfunction

endpackage

// File: rtl/console_port_mux.sv
// CPU-priority mux onto the text-buffer port; zero latency, combinational.
// eng_go_o is high only when the engine's access is actually issued this cycle.
module console_port_mux (
  input  logic        cpu_req_i,
  input  logic [11:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_wdata_i,
  input  logic        eng_req_i,
  input  logic [11:0] eng_addr_i,
  input  logic        eng_we_i,
  input  logic        eng_oe_i,
  input  logic [7:0]  eng_wdata_i,
  output logic        eng_go_o,
  output logic [11:0] mem_addr_o,
  output logic        mem_we_o,
  output logic        mem_oe_o,
  output logic [7:0]  mem_wdata_o
);

  assign eng_go_o = eng_req_i && !cpu_req_i;

  always_comb begin
    if (cpu_req_i) begin
      mem_addr_o  = cpu_addr_i;
      mem_we_o    = cpu_we_i;
      mem_oe_o    = !cpu_we_i;
      mem_wdata_o = cpu_wdata_i;
    end else begin
      mem_addr_o  = eng_addr_i;
      mem_we_o    = eng_we_i;
      mem_oe_o    = eng_oe_i;
      mem_wdata_o = eng_wdata_i;
    end
  end

endmodule

// File: rtl/textbuffer_console.sv
// Terminal sequencer: byte stream in, character/attribute cell writes, scroll and clear out.
// Accepts a byte only in IDLE; every engine access stalls while the CPU holds the port.
module textbuffer_console
  import console_pkg::*;
#(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned HEIGHT   = 16,
  parameter logic [11:0] BASEADDR = 12'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  cur_attr,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [4:0]  cursor_col,
  output logic [3:0]  cursor_row,
  output logic        busy
);

  localparam logic [11:0] ROW_OFF   = 12'(WIDTH);
  localparam logic [11:0] ATTR_BASE = BASEADDR + 12'(WIDTH * HEIGHT);
  localparam logic [11:0] LAST_CELL = 12'(WIDTH * HEIGHT - 1);
  localparam logic [11:0] LAST_SCR  = 12'(WIDTH * (HEIGHT - 1) - 1);
  localparam logic [4:0]  LAST_COL  = 5'(WIDTH - 1);
  localparam logic [3:0]  LAST_ROW  = 4'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  logic [11:0] idx_q, idx_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  chr_q, chr_d;
  logic [7:0]  cap_q;
  logic        rd_pend_q, rd_pend_d;

  logic        accept, eng_req, eng_go, eng_we, eng_oe;
  logic [11:0] eng_addr, cur_off;
  logic [7:0]  eng_wdata, rd_data;

  assign in_ready   = (state_q == IDLE);
  assign busy       = !in_ready;
  assign accept     = in_valid && in_ready;
  assign eng_req    = (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign cur_off    = cell_off(row_q, col_q, ROW_OFF);
  // Read data is live the cycle after the read; later (after a stall) it comes from the capture register.
  assign rd_data    = rd_pend_q ? mem_rdata : cap_q;
  assign rd_pend_d  = eng_go && eng_oe;

  console_port_mux u_mux (
    .cpu_req_i  (cpu_req),
    .cpu_addr_i (cpu_addr),
    .cpu_we_i   (cpu_we),
    .cpu_wdata_i(cpu_wdata),
    .eng_req_i  (eng_req),
    .eng_addr_i (eng_addr),
    .eng_we_i   (eng_we),
    .eng_oe_i   (eng_oe),
    .eng_wdata_i(eng_wdata),
    .eng_go_o   (eng_go),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_oe_o   (mem_oe),
    .mem_wdata_o(mem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q     <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      attr_q    <= '0;
      chr_q     <= '0;
      cap_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      attr_q    <= attr_d;
      chr_q     <= chr_d;
      rd_pend_q <= rd_pend_d;
      if (rd_pend_q) cap_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    attr_d  = attr_q;
    chr_d   = chr_q;
    unique case (state_q)
      IDLE: if (accept) begin
        attr_d = cur_attr;
        chr_d  = in_data;
        if (is_printable(in_data)) begin
          state_d = WR_C;
        end else begin
          case (in_data)
            LF: begin
              col_d = '0;
              if (row_q < LAST_ROW) begin
                row_d = row_q + 4'd1;
              end else begin
                idx_d   = '0;
                state_d = SCR_RD_C;
              end
            end
            CR: col_d = '0;
            BS: if (col_q != 5'd0) col_d = col_q - 5'd1;
            FF: begin
              idx_d   = '0;
              state_d = CLR_C;
            end
            default: ;
          endcase
        end
      end
      WR_C: if (eng_go) state_d = WR_A;
      WR_A: if (eng_go) begin
        state_d = IDLE;
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (row_q < LAST_ROW) begin
            row_d = row_q + 4'd1;
          end else begin
            idx_d   = '0;
            state_d = SCR_RD_C;
          end
        end else begin
          col_d = col_q + 5'd1;
        end
      end
      CLR_C: if (eng_go) state_d = CLR_A;
      CLR_A: if (eng_go) begin
        if (idx_q == LAST_CELL) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = CLR_C;
        end
      end
      SCR_RD_C: if (eng_go) state_d = SCR_WR_C;
      SCR_WR_C: if (eng_go) state_d = SCR_RD_A;
      SCR_RD_A: if (eng_go) state_d = SCR_WR_A;
      SCR_WR_A: if (eng_go) begin
        idx_d   = idx_q + 12'd1;
        state_d = (idx_q == LAST_SCR) ? FILL_C : SCR_RD_C;
      end
      FILL_C: if (eng_go) state_d = FILL_A;
      FILL_A: if (eng_go) begin
        if (idx_q == LAST_CELL) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = FILL_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    eng_addr  = '0;
    eng_we    = 1'b0;
    eng_oe    = 1'b0;
    eng_wdata = '0;
    unique case (state_q)
      WR_C:     begin eng_addr = BASEADDR + cur_off;          eng_we = 1'b1; eng_wdata = chr_q;   end
      WR_A:     begin eng_addr = ATTR_BASE + cur_off;         eng_we = 1'b1; eng_wdata = attr_q;  end
      CLR_C:    begin eng_addr = BASEADDR + idx_q;            eng_we = 1'b1; eng_wdata = SPACE;   end
      CLR_A:    begin eng_addr = ATTR_BASE + idx_q;           eng_we = 1'b1; eng_wdata = attr_q;  end
      SCR_RD_C: begin eng_addr = BASEADDR + idx_q + ROW_OFF;  eng_oe = 1'b1;                      end
      SCR_WR_C: begin eng_addr = BASEADDR + idx_q;            eng_we = 1'b1; eng_wdata = rd_data; end
      SCR_RD_A: begin eng_addr = ATTR_BASE + idx_q + ROW_OFF; eng_oe = 1'b1;                      end
      SCR_WR_A: begin eng_addr = ATTR_BASE + idx_q;           eng_we = 1'b1; eng_wdata = rd_data; end
      FILL_C:   begin eng_addr = BASEADDR + idx_q;            eng_we = 1'b1; eng_wdata = SPACE;   end
      FILL_A:   begin eng_addr = ATTR_BASE + idx_q;           eng_we = 1'b1; eng_wdata = attr_q;  end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_textbuffer_console.sv
// Bench for textbuffer_console: text-buffer memory model, write scoreboard and directed byte stream.
module tb_textbuffer_console;

  localparam int          W     = 20;
  localparam int          H     = 16;
  localparam logic [11:0] BASE  = 12'h400;
  localparam logic [11:0] ABASE = 12'h540;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  cur_attr = '0;
  logic        cpu_req = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [11:0] mem_addr;
  logic        mem_we, mem_oe;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [4:0]  cursor_col;
  logic [3:0]  cursor_row;
  logic        busy;

  textbuffer_console dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .cur_attr(cur_attr),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // Text-buffer model: synchronous write, read data valid the cycle after oe.
  logic [7:0] mem [0:4095] = '{default: 8'h00};
  logic [7:0] rd_q = 8'h00;
  assign mem_rdata = rd_q;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_oe) rd_q <= mem[mem_addr];
  end

  int n_vec  = 0;
  int n_miss = 0;
  logic [19:0] sb [$];

  logic [7:0] ref_c [0:W*H-1] = '{default: 8'h00};
  logic [7:0] ref_a [0:W*H-1] = '{default: 8'h00};
  logic [4:0] mcol = '0;
  logic [3:0] mrow = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: CPU pass-through and every engine write against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (cpu_req) begin
        chk("cpu_pass", {10'd0, mem_addr, mem_we, mem_oe, mem_wdata},
            {10'd0, cpu_addr, cpu_we, !cpu_we, cpu_wdata});
      end else if (mem_we) begin
        if (sb.size() == 0) chk("unexpected_write", {12'd0, mem_addr, mem_wdata}, 32'hFFFFFFFF);
        else chk("eng_write", {12'd0, mem_addr, mem_wdata}, {12'd0, sb.pop_front()});
      end
    end
  end

  task automatic push(input logic [11:0] a, input logic [7:0] d);
    sb.push_back({a, d});
  endtask

  task automatic model_scroll(input logic [7:0] a);
    for (int i = 0; i < W*(H-1); i++) begin
      push(BASE + 12'(i), ref_c[i+W]);  ref_c[i] = ref_c[i+W];
      push(ABASE + 12'(i), ref_a[i+W]); ref_a[i] = ref_a[i+W];
    end
    for (int i = W*(H-1); i < W*H; i++) begin
      push(BASE + 12'(i), 8'h20); ref_c[i] = 8'h20;
      push(ABASE + 12'(i), a);    ref_a[i] = a;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] a, output int exp_busy);
    int off;
    exp_busy = 0;
    if (b >= 8'h20 && b != 8'h7F) begin
      off = int'(mrow) * W + int'(mcol);
      push(BASE + 12'(off), b);  ref_c[off] = b;
      push(ABASE + 12'(off), a); ref_a[off] = a;
      exp_busy = 2;
      if (mcol == 5'(W-1)) begin
        mcol = 0;
        if (mrow < 4'(H-1)) mrow++;
        else begin model_scroll(a); exp_busy += 4*W*(H-1) + 2*W; end
      end else mcol++;
    end else if (b == 8'h0A) begin
      mcol = 0;
      if (mrow < 4'(H-1)) mrow++;
      else begin model_scroll(a); exp_busy = 4*W*(H-1) + 2*W; end
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h08) begin
      if (mcol != 0) mcol--;
    end else if (b == 8'h0C) begin
      for (int i = 0; i < W*H; i++) begin
        push(BASE + 12'(i), 8'h20); ref_c[i] = 8'h20;
        push(ABASE + 12'(i), a);    ref_a[i] = a;
      end
      mcol = 0; mrow = 0; exp_busy = 2*W*H;
    end
  endtask

  task automatic accept(input logic [7:0] b, input logic [7:0] a, output int exp_busy);
    int g;
    model_byte(b, a, exp_busy);
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 5000) begin @(negedge clk); g++; end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in_data = b; cur_attr = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_busy);
    int cnt;
    cnt = 0;
    for (int g = 0; g < 5000; g++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk(name, 32'(cnt), 32'(exp_busy));
  endtask

  task automatic send(input string name, input logic [7:0] b, input logic [7:0] a);
    int eb;
    accept(b, a, eb);
    wait_idle(name, eb);
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cursor"}, {23'd0, cursor_row, cursor_col}, 32'd0);
    chk({tag, "_mem_ctl"}, {30'd0, mem_we, mem_oe}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic chk_planes(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < W*H; i++) begin
      if (mem[BASE + 12'(i)] !== ref_c[i] || mem[ABASE + 12'(i)] !== ref_a[i]) bad++;
    end
    chk({tag, "_plane_mismatch_cells"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int eb, cnt, n_cpu;
    reset = 1'b0;
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    send("busy_A", 8'h41, 8'h1F);
    chk("cursor_after_A", {23'd0, cursor_row, cursor_col}, {23'd0, 4'd0, 5'd1});
    chk("in_ready_after_A", 32'(in_ready), 32'd1);
    chk("mem_A", {16'd0, mem[12'h400], mem[12'h540]}, 32'h411F);

    send("busy_CR", 8'h0D, 8'h00);
    for (int k = 0; k < W; k++) send("busy_row0", 8'h61 + 8'(k), 8'(k));
    chk("cursor_wrap", {23'd0, cursor_row, cursor_col}, {23'd0, 4'd1, 5'd0});
    chk("last_row0_cell", 32'(mem[12'h413]), 32'h74);

    send("busy_Z", 8'h5A, 8'h33);
    send("busy_BS", 8'h08, 8'h00);
    send("busy_BS0", 8'h08, 8'h00);
    send("busy_BEL", 8'h07, 8'h00);
    send("busy_DEL", 8'h7F, 8'h00);
    chk("cursor_bs", {23'd0, cursor_row, cursor_col}, {23'd0, 4'd1, 5'd0});

    for (int k = 0; k < 14; k++) send("busy_lf", 8'h0A, 8'h00);
    chk("cursor_row15", {23'd0, cursor_row, cursor_col}, {23'd0, 4'd15, 5'd0});
    cpu_write(12'h414, 8'h55);
    ref_c[20] = 8'h55;
    send("busy_scroll", 8'h0A, 8'h0E);
    chk("cursor_after_scroll", {23'd0, cursor_row, cursor_col}, {23'd0, 4'd15, 5'd0});
    chk("scrolled_char0", 32'(mem[12'h400]), 32'h55);
    chk("fill_row_first", 32'(mem[12'h400 + 12'd300]), 32'h20);
    chk("fill_row_last", 32'(mem[12'h400 + 12'd319]), 32'h20);
    chk_planes("scroll1");

    // Scroll with CPU pre-emption: writes, plus one read, stolen from the engine.
    accept(8'h0A, 8'h4B, eb);
    cnt = 0; n_cpu = 0;
    for (int g = 0; g < 6000; g++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if ((cnt >= 10 && cnt <= 16) || cnt == 100 || cnt == 101 || cnt == 205) begin
        cpu_req = 1'b1; cpu_we = (cnt != 101); cpu_addr = 12'h010 + 12'(cnt); cpu_wdata = 8'(cnt);
        n_cpu++;
      end else begin
        cpu_req = 1'b0; cpu_we = 1'b0;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("busy_scroll_cpu", 32'(cnt), 32'(eb + 10));
    chk("cpu_cycles", 32'(n_cpu), 32'd10);
    chk("cpu_write_landed", 32'(mem[12'h01A]), 32'h0A);
    chk_planes("scroll2");

    send("busy_clear", 8'h0C, 8'h70);
    chk("cursor_after_clear", {23'd0, cursor_row, cursor_col}, 32'd0);
    chk("clear_attr_last", 32'(mem[12'h67F]), 32'h70);
    chk_planes("clear");

    // Reset in the middle of a scroll.
    for (int k = 0; k < 15; k++) send("busy_lf2", 8'h0A, 8'h00);
    accept(8'h0A, 8'h22, eb);
    repeat (50) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    mcol = 0; mrow = 0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("in_ready_post_reset", 32'(in_ready), 32'd1);
    chk("cursor_post_reset", {23'd0, cursor_row, cursor_col}, 32'd0);
    send("busy_B", 8'h42, 8'h02);
    chk("cursor_after_B", {23'd0, cursor_row, cursor_col}, {23'd0, 4'd0, 5'd1});
    chk("mem_B", {16'd0, mem[12'h400], mem[12'h540]}, 32'h4202);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
